conveyor_writeback: RTL

// Owns conveyor register storage and head pointer feeding conveyor_control. Each cycle it

---
 rtl/conveyor_writeback_if.sv | 36 +++
 rtl/conveyor_writeback.sv | 115 +++++++++++
 2 files changed

// File: rtl/conveyor_writeback_if.sv
// Bus bundle between conveyor_control / async requesters and conveyor_writeback.
// The slave side is the writeback block; the master side drives head updates and returns.
interface conveyor_writeback_if #(
  parameter int WORD_WIDTH          = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int RETURN_PORTS        = 2
);
  localparam int SIZE    = 1 << CONVEYOR_ADDR_WIDTH;
  localparam int ENTRY_W = 4 + WORD_WIDTH;

  logic                                            advance;
  logic [CONVEYOR_ADDR_WIDTH-1:0]                  conveyor_head_next;
  logic                                            push_valid;
  logic [WORD_WIDTH-1:0]                           push_value;
  logic                                            dispatch_valid;
  logic [CONVEYOR_ADDR_WIDTH-1:0]                  dispatch_tag;
  logic [RETURN_PORTS-1:0]                         ret_valid;
  logic [RETURN_PORTS-1:0]                         ret_ready;
  logic [RETURN_PORTS-1:0][CONVEYOR_ADDR_WIDTH-1:0] ret_tag;
  logic [RETURN_PORTS-1:0][2:0]                    ret_fault;
  logic [RETURN_PORTS-1:0][WORD_WIDTH-1:0]         ret_value;
  logic [SIZE-1:0][ENTRY_W-1:0]                    conveyor;
  logic [CONVEYOR_ADDR_WIDTH-1:0]                  conveyor_head;

  modport master (
    output advance, conveyor_head_next, push_valid, push_value, dispatch_valid,
           ret_valid, ret_tag, ret_fault, ret_value,
    input  dispatch_tag, ret_ready, conveyor, conveyor_head
  );

  modport slave (
    input  advance, conveyor_head_next, push_valid, push_value, dispatch_valid,
           ret_valid, ret_tag, ret_fault, ret_value,
    output dispatch_tag, ret_ready, conveyor, conveyor_head
  );
endinterface

// File: rtl/conveyor_writeback.sv
// Conveyor slot storage and head pointer: front push/dispatch writes at the new head,
// plus per-port skid buffers for async results drained round-robin into their slots.
module conveyor_writeback #(
  parameter int WORD_WIDTH          = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int RETURN_PORTS        = 2,
  parameter int RETURN_ADDR_WIDTH   = 1
) (
  input logic                 clk,
  input logic                 reset,
  conveyor_writeback_if.slave bus
);
  localparam int SIZE = 1 << CONVEYOR_ADDR_WIDTH;
  localparam int CAW  = CONVEYOR_ADDR_WIDTH;
  localparam int RP   = RETURN_PORTS;
  localparam int RAW  = RETURN_ADDR_WIDTH;
  localparam logic [2:0] F_NONE = 3'd0;

  typedef struct packed {
    logic                  finished;
    logic [2:0]            fault;
    logic [WORD_WIDTH-1:0] value;
  } slot_t;

  typedef struct packed {
    logic [CAW-1:0]        tag;
    logic [2:0]            fault;
    logic [WORD_WIDTH-1:0] value;
  } ret_t;

  slot_t [SIZE-1:0] slot_q, slot_d;
  logic [CAW-1:0]   head_q, head_d;
  logic [RAW-1:0]   rr_q, rr_d;
  logic [RP-1:0]    skid_vld_q, skid_vld_d;
  ret_t [RP-1:0]    skid_q, skid_d;

  logic           front_wr, win_found, collision, ret_wr;
  logic [RAW-1:0] win_idx, cand;
  ret_t           win;
  int             scan, nxt;

  // First occupied skid at or after rr_q, wrapping at RP-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    scan      = 0;
    for (int k = 0; k < RP; k++) begin
      scan = int'(rr_q) + k;
      if (scan >= RP) scan = scan - RP;
      cand = RAW'(scan);
      if (!win_found && skid_vld_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win       = skid_q[win_idx];
  assign front_wr  = bus.advance && (bus.dispatch_valid || bus.push_valid);
  // The front write owns its slot this cycle; the return retries next cycle.
  assign collision = front_wr && (win.tag == bus.conveyor_head_next);
  assign ret_wr    = win_found && !collision;

  always_comb begin
    slot_d     = slot_q;
    head_d     = head_q;
    rr_d       = rr_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    nxt        = 0;
    if (ret_wr) begin
      slot_d[win.tag]     = '{finished: 1'b1, fault: win.fault, value: win.value};
      skid_vld_d[win_idx] = 1'b0;
      nxt = int'(win_idx) + 1;
      if (nxt >= RP) nxt = 0;
      rr_d = RAW'(nxt);
    end
    if (front_wr) begin
      if (bus.dispatch_valid)
        slot_d[bus.conveyor_head_next] = '{finished: 1'b0, fault: F_NONE, value: '0};
      else
        slot_d[bus.conveyor_head_next] = '{finished: 1'b1, fault: F_NONE, value: bus.push_value};
    end
    if (bus.advance) head_d = bus.conveyor_head_next;
    // Capture only into an empty skid, so capture and drain never hit the same port.
    for (int i = 0; i < RP; i++) begin
      if (bus.ret_valid[i] && !skid_vld_q[i]) begin
        skid_vld_d[i] = 1'b1;
        skid_d[i]     = '{tag: bus.ret_tag[i], fault: bus.ret_fault[i], value: bus.ret_value[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SIZE; s++) slot_q[s] <= '{finished: 1'b1, fault: F_NONE, value: '0};
      head_q     <= '0;
      rr_q       <= '0;
      skid_vld_q <= '0;
      skid_q     <= '0;
    end else begin
      slot_q     <= slot_d;
      head_q     <= head_d;
      rr_q       <= rr_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.dispatch_tag  = bus.conveyor_head_next;
  assign bus.ret_ready     = ~skid_vld_q;
  assign bus.conveyor      = slot_q;
  assign bus.conveyor_head = head_q;
endmodule
